// File: rtl/scaler_pipe_pkg.sv
// Shared constants for the CORDIC gain-compensation scaler.
package scaler_pipe_pkg;

  // Per-sample mode codes; any other code passes the sample through.
  localparam logic [1:0] MODE_CIRCULAR   = 2'b01;
  localparam logic [1:0] MODE_HYPERBOLIC = 2'b10;

  localparam int NUM_TERMS      = 9;
  localparam int SCALER_LATENCY = 3;

  // Shift lists: gain = sum of 2^-shift over the list (shift 0 = the sample itself).
  localparam int KC_SHIFTS [NUM_TERMS] = '{1, 4, 5, 7, 8, 10, 11, 12, 13};
  localparam int KH_SHIFTS [NUM_TERMS] = '{0, 3, 4, 6, 8, 12, 13, 14, 15};

  typedef enum logic [1:0] {
    SET_PASS = 2'd0,
    SET_CIRC = 2'd1,
    SET_HYP  = 2'd2
  } term_set_e;

  function automatic term_set_e decode_mode(input logic [1:0] m);
    case (m)
      MODE_CIRCULAR:   return SET_CIRC;
      MODE_HYPERBOLIC: return SET_HYP;
      default:         return SET_PASS;
    endcase
  endfunction

endpackage

// File: rtl/scaler_term_sel.sv
// Combinational term generator: mode + sample -> nine sign-extended shifted terms.
// Unused terms are zero so the adder tree is the same for every mode.
module scaler_term_sel
  import scaler_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        [1:0]                      mode,
  input  logic signed [WIDTH-1:0]                number,
  output logic        [NUM_TERMS-1:0][WIDTH+1:0] terms
);

  logic signed [WIDTH+1:0] ext;
  term_set_e               term_set;

  // Extending before the shift gives the same bits as shift-truncate-then-extend.
  assign ext      = {{2{number[WIDTH-1]}}, number};
  assign term_set = decode_mode(mode);

  // Select each term from the shift list for the sample's mode.
  always_comb begin
    terms = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      case (term_set)
        SET_CIRC: terms[i] = ext >>> KC_SHIFTS[i];
        SET_HYP:  terms[i] = ext >>> KH_SHIFTS[i];
        default:  if (i == 0) terms[i] = ext;
      endcase
    end
  end

endmodule

// File: rtl/scaler_pipe.sv
// Three-stage pipelined CORDIC gain-compensation scaler with valid/ready
// flow control, per-sample mode/tag and saturating (or wrapping) output.
module scaler_pipe
  import scaler_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] number,
  input  logic        [1:0]       mode,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] answer,
  output logic        [TAG_W-1:0] out_tag,
  output logic                    ovf
);

  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] MAX_V = $signed({3'b000, {(WIDTH-1){1'b1}}});
  localparam logic signed [EW-1:0] MIN_V = $signed({3'b111, {(WIDTH-1){1'b0}}});

  logic [NUM_TERMS-1:0][EW-1:0] terms;
  logic [SCALER_LATENCY:1]      vld_pipe;
  logic [SCALER_LATENCY:1]      en;

  logic signed [EW-1:0]    s1_pair [4];
  logic signed [EW-1:0]    s1_single;
  logic        [TAG_W-1:0] s1_tag;
  logic signed [EW-1:0]    s2_sum [2];
  logic signed [EW-1:0]    s2_single;
  logic        [TAG_W-1:0] s2_tag;

  logic signed [EW-1:0]    final_sum;
  logic                    hi, lo;
  logic        [WIDTH-1:0] result;

  scaler_term_sel #(.WIDTH(WIDTH)) u_term_sel (
    .mode   (mode),
    .number (number),
    .terms  (terms)
  );

  // A stage loads when it is empty or its successor is taking its contents.
  assign en[3]     = !vld_pipe[3] || out_ready;
  assign en[2]     = !vld_pipe[2] || en[3];
  assign en[1]     = !vld_pipe[1] || en[2];
  assign in_ready  = en[1];
  assign out_valid = vld_pipe[3];

  // Valid shift register; each bit advances only when its stage is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (en[1]) vld_pipe[1] <= in_valid;
      if (en[2]) vld_pipe[2] <= vld_pipe[1];
      if (en[3]) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // S1: four pair sums plus the odd ninth term.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) s1_pair[k] <= '0;
      s1_single <= '0;
      s1_tag    <= '0;
    end else if (en[1] && in_valid) begin
      for (int k = 0; k < 4; k++)
        s1_pair[k] <= $signed(terms[2*k]) + $signed(terms[2*k+1]);
      s1_single <= $signed(terms[8]);
      s1_tag    <= in_tag;
    end
  end

  // S2: reduce to two sums, carry the single term forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sum[0] <= '0;
      s2_sum[1] <= '0;
      s2_single <= '0;
      s2_tag    <= '0;
    end else if (en[2] && vld_pipe[1]) begin
      s2_sum[0] <= s1_pair[0] + s1_pair[1];
      s2_sum[1] <= s1_pair[2] + s1_pair[3];
      s2_single <= s1_single;
      s2_tag    <= s1_tag;
    end
  end

  // Final sum and range check; the two guard bits hold any hyperbolic overshoot.
  always_comb begin
    final_sum = s2_sum[0] + s2_sum[1] + s2_single;
    hi        = final_sum > MAX_V;
    lo        = final_sum < MIN_V;
    result    = final_sum[WIDTH-1:0];
    if (SATURATE) begin
      if (hi)      result = MAX_V[WIDTH-1:0];
      else if (lo) result = MIN_V[WIDTH-1:0];
    end
  end

  // S3: output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      answer  <= '0;
      out_tag <= '0;
      ovf     <= 1'b0;
    end else if (en[3] && vld_pipe[2]) begin
      answer  <= result;
      out_tag <= s2_tag;
      ovf     <= hi || lo;
    end
  end

endmodule

// File: tb/tb_scaler_pipe.sv
// Directed bench for scaler_pipe: one saturating and one wrapping instance share inputs.
module tb_scaler_pipe;
  import scaler_pipe_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready;
  logic [W-1:0]  number;
  logic [1:0]    mode;
  logic [TW-1:0] in_tag;

  logic          in_ready_s, out_valid_s, ovf_s;
  logic [W-1:0]  answer_s;
  logic [TW-1:0] out_tag_s;
  logic          in_ready_w, out_valid_w, ovf_w;
  logic [W-1:0]  answer_w;
  logic [TW-1:0] out_tag_w;

  int checks = 0;
  int errors = 0;

  scaler_pipe #(.WIDTH(W), .TAG_W(TW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .number(number), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .answer(answer_s), .out_tag(out_tag_s), .ovf(ovf_s)
  );

  scaler_pipe #(.WIDTH(W), .TAG_W(TW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .number(number), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .answer(answer_w), .out_tag(out_tag_w), .ovf(ovf_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle (called just after a rising edge).
  task automatic send(input logic [W-1:0] n, input logic [1:0] m, input logic [TW-1:0] t);
    number = n; mode = m; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    chk("send_in_ready", 64'(in_ready_s), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result (bounded), check latency and both instances' outputs.
  task automatic expect_out(input string name, input logic [W-1:0] a_s, input logic o_s,
                            input logic [W-1:0] a_w, input logic o_w, input logic [TW-1:0] t);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid_s && lat < 10);
    chk({name, "_latency"}, 64'(lat), 64'd3);
    chk({name, "_valid_w"}, 64'(out_valid_w), 64'd1);
    chk({name, "_ans_sat"}, 64'(answer_s), 64'(a_s));
    chk({name, "_ovf_sat"}, 64'(ovf_s), 64'(o_s));
    chk({name, "_ans_wrap"}, 64'(answer_w), 64'(a_w));
    chk({name, "_ovf_wrap"}, 64'(ovf_w), 64'(o_w));
    chk({name, "_tag"}, 64'(out_tag_s), 64'(t));
    @(posedge clk); #1;
  endtask

  logic [W-1:0]  rnd, held_ans;
  logic [TW-1:0] held_tag;
  int            si, ri, cyc, seen;
  bit            saw_block, stalled_prev, acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    number = '0; mode = 2'b00; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_s), 64'd0);
    chk("rst_answer",    64'(answer_s),    64'd0);
    chk("rst_out_tag",   64'(out_tag_s),   64'd0);
    chk("rst_ovf",       64'(ovf_s),       64'd0);
    chk("rst_in_ready",  64'(in_ready_s),  64'd1);
    @(posedge clk); #1;

    // Circular and hyperbolic gains on +/-1.0 (Q16)
    send(32'h0001_0000, MODE_CIRCULAR, 4'h1);
    expect_out("circ_pos", 32'h0000_9B78, 1'b0, 32'h0000_9B78, 1'b0, 4'h1);
    send(32'h0001_0000, MODE_HYPERBOLIC, 4'h2);
    expect_out("hyp_pos", 32'h0001_351E, 1'b0, 32'h0001_351E, 1'b0, 4'h2);
    send(32'hFFFF_0000, MODE_HYPERBOLIC, 4'h3);
    expect_out("hyp_neg", 32'hFFFE_CAE2, 1'b0, 32'hFFFE_CAE2, 1'b0, 4'h3);

    // Overflow: positive and negative, saturate vs wrap
    send(32'h7000_0000, MODE_HYPERBOLIC, 4'h4);
    expect_out("hyp_ovf_pos", 32'h7FFF_FFFF, 1'b1, 32'h873D_2000, 1'b1, 4'h4);
    send(32'h8000_0000, MODE_HYPERBOLIC, 4'h5);
    expect_out("hyp_ovf_neg", 32'h8000_0000, 1'b1, 32'h6571_0000, 1'b1, 4'h5);
    // Most negative input in circular mode stays in range
    send(32'h8000_0000, MODE_CIRCULAR, 4'h6);
    expect_out("circ_min", 32'hB244_0000, 1'b0, 32'hB244_0000, 1'b0, 4'h6);

    // Passthrough codes
    rnd = $urandom;
    send(rnd, 2'b11, 4'h7);
    expect_out("pass_11", rnd, 1'b0, rnd, 1'b0, 4'h7);
    send(32'h7FFF_FFFF, 2'b00, 4'h8);
    expect_out("pass_00", 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0, 4'h8);

    // Back-to-back 8 samples, alternating modes, downstream stall in cycles 2..6
    si = 0; ri = 0; cyc = 0; saw_block = 1'b0; stalled_prev = 1'b0;
    held_ans = '0; held_tag = '0;
    while (ri < 8 && cyc < 60) begin
      out_ready = !(cyc >= 2 && cyc <= 6);
      in_valid  = (si < 8);
      if (si < 8) begin
        number = 32'h0001_0000 << si;
        mode   = (si % 2 == 0) ? MODE_CIRCULAR : MODE_HYPERBOLIC;
        in_tag = TW'(si);
      end
      @(negedge clk);
      acc = in_valid && in_ready_s;
      if (!in_ready_s && !saw_block) begin
        saw_block = 1'b1;
        chk("b2b_accepted_before_block", 64'(si), 64'd3);
      end
      if (stalled_prev) begin
        chk("b2b_hold_valid", 64'(out_valid_s), 64'd1);
        chk("b2b_hold_answer", 64'(answer_s), 64'(held_ans));
        chk("b2b_hold_tag", 64'(out_tag_s), 64'(held_tag));
      end
      if (out_valid_s && out_ready) begin
        chk("b2b_answer", 64'(answer_s),
            64'((ri % 2 == 0) ? (32'h0000_9B78 << ri) : (32'h0001_351E << ri)));
        chk("b2b_tag", 64'(out_tag_s), 64'(ri));
        chk("b2b_ovf", 64'(ovf_s), 64'd0);
        ri++;
      end
      stalled_prev = out_valid_s && !out_ready;
      held_ans     = answer_s;
      held_tag     = out_tag_s;
      @(posedge clk); #1;
      if (acc) si++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("b2b_all_out", 64'(ri), 64'd8);
    chk("b2b_saw_block", 64'(saw_block), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset with three samples in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      number = 32'h7000_0000; mode = MODE_HYPERBOLIC; in_tag = TW'(9 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid_s), 64'd1);
    chk("full_in_ready", 64'(in_ready_s), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid_s), 64'd0);
    chk("midrst_answer", 64'(answer_s), 64'd0);
    chk("midrst_ovf", 64'(ovf_s), 64'd0);
    chk("midrst_out_tag", 64'(out_tag_s), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_s), 64'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_s || out_valid_w) seen++;
    end
    chk("midrst_none_emitted", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
